output_port_scheduler: RTL and testbench

- Sequential round-robin scheduler for one output port of the 4x4 switch.
- Arbitrates among four input-port packet requesters and loads the packet length into a down-counter.
- Holds the grant for the whole packet, counting words out under downstream backpressure.
- Enforces an inter-packet gap, then rearbitrates. One instance per output port.

---
 rtl/switch_pkg.sv | 32 +++
 rtl/rr_select.sv | 31 +++
 rtl/output_port_scheduler.sv | 148 ++++++++++++++
 tb/tb_output_port_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Types and helpers shared by the switch output-port logic: scheduler states,
// port identifiers and id-to-one-hot conversion.
package switch_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [2:0] PORT_NONE = 3'd0;
  localparam logic [2:0] PORT_1    = 3'd1;
  localparam logic [2:0] PORT_2    = 3'd2;
  localparam logic [2:0] PORT_3    = 3'd3;
  localparam logic [2:0] PORT_4    = 3'd4;

  function automatic logic [3:0] id_to_onehot(input logic [2:0] id);
    logic [3:0] oh;
    oh = 4'b0000;
    case (id)
      PORT_1:  oh = 4'b0001;
      PORT_2:  oh = 4'b0010;
      PORT_3:  oh = 4'b0100;
      PORT_4:  oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: searches the four requesters starting at
// the port after the last-served one, wrapping 4 -> 1.
module rr_select
  import switch_pkg::*;
(
  input  logic [3:0] i_valid,
  input  logic [2:0] i_last_id,
  output logic [2:0] o_winner,
  output logic       o_any_valid
);

  logic [1:0] w_start;

  // Zero-based index of the first candidate; last id 4 (or none) restarts at port 1.
  assign w_start     = (i_last_id >= PORT_4) ? 2'd0 : i_last_id[1:0];
  assign o_any_valid = |i_valid;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    logic [1:0] w_idx;
    w_idx    = w_start;
    o_winner = PORT_NONE;
    for (int k = 3; k >= 0; k--) begin
      w_idx = w_start + 2'(k);
      if (i_valid[w_idx]) begin
        o_winner = {1'b0, w_idx} + 3'd1;
      end
    end
  end

endmodule

// File: rtl/output_port_scheduler.sv
// Output-port scheduler: round-robin grant among four inputs, holds the grant
// for a whole packet while counting words out, then enforces an idle gap.
module output_port_scheduler
  import switch_pkg::*;
#(
  parameter int CNT_W      = DEFAULT_CNT_W,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p1_valid,
  input  logic             p2_valid,
  input  logic             p3_valid,
  input  logic             p4_valid,
  input  logic [CNT_W-1:0] p1_len,
  input  logic [CNT_W-1:0] p2_len,
  input  logic [CNT_W-1:0] p3_len,
  input  logic [CNT_W-1:0] p4_len,
  input  logic             out_ready,
  output logic [3:0]       grant,
  output logic [3:0]       word_rd,
  output logic             out_valid,
  output logic             pkt_start,
  output logic             pkt_end,
  output logic [2:0]       active_packet,
  output logic [2:0]       priority_queue,
  output logic [CNT_W-1:0] down_counter
);

  localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_grant;
  logic [2:0]       r_active;
  logic [2:0]       r_prio;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap;
  logic             r_first;

  logic [3:0]       w_valid;
  logic [2:0]       w_winner;
  logic             w_any_valid;
  logic [CNT_W-1:0] w_len_sel;
  logic [CNT_W-1:0] w_len_load;
  logic             w_xfer;
  logic             w_accept;
  logic             w_last;

  assign w_valid = {p4_valid, p3_valid, p2_valid, p1_valid};

  rr_select u_rr_select (
    .i_valid     (w_valid),
    .i_last_id   (r_prio),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  always_comb begin
    w_len_sel = '0;
    case (w_winner)
      PORT_1:  w_len_sel = p1_len;
      PORT_2:  w_len_sel = p2_len;
      PORT_3:  w_len_sel = p3_len;
      PORT_4:  w_len_sel = p4_len;
      default: w_len_sel = '0;
    endcase
  end

  // A zero-length request still occupies one word slot.
  assign w_len_load = (w_len_sel == '0) ? CNT_ONE : w_len_sel;

  assign w_xfer   = (r_state == XFER);
  assign w_accept = w_xfer & out_ready;
  assign w_last   = w_accept & (r_cnt == CNT_ONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_valid) w_state_nxt = XFER;
      XFER:    if (w_last) w_state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (r_gap <= GAP_ONE) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant  <= '0;
      r_active <= PORT_NONE;
      r_prio   <= PORT_NONE;
      r_cnt    <= '0;
      r_gap    <= '0;
      r_first  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_grant  <= id_to_onehot(w_winner);
            r_active <= w_winner;
            r_prio   <= w_winner;
            r_cnt    <= w_len_load;
            r_first  <= 1'b1;
          end
        end
        XFER: begin
          if (out_ready) begin
            r_first <= 1'b0;
            if (r_cnt == CNT_ONE) begin
              r_cnt    <= '0;
              r_grant  <= '0;
              r_active <= PORT_NONE;
              r_gap    <= GAP_LOAD;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
        end
        GAP: begin
          r_gap <= (r_gap > GAP_ONE) ? r_gap - GAP_ONE : '0;
        end
        default: ;
      endcase
    end
  end

  assign grant          = r_grant;
  assign word_rd        = w_xfer ? (r_grant & {4{out_ready}}) : 4'b0000;
  assign out_valid      = w_xfer;
  assign pkt_start      = w_xfer & r_first;
  assign pkt_end        = w_last;
  assign active_packet  = r_active;
  assign priority_queue = r_prio;
  assign down_counter   = r_cnt;

endmodule

// File: tb/tb_output_port_scheduler.sv
// Scoreboard bench for output_port_scheduler: expected words are queued as
// requests are raised and compared whenever the scheduler reads a word.
module tb_output_port_scheduler;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             p1_valid, p2_valid, p3_valid, p4_valid;
  logic [CNT_W-1:0] p1_len, p2_len, p3_len, p4_len;
  logic             out_ready;
  logic [3:0]       grant;
  logic [3:0]       word_rd;
  logic             out_valid;
  logic             pkt_start;
  logic             pkt_end;
  logic [2:0]       active_packet;
  logic [2:0]       priority_queue;
  logic [CNT_W-1:0] down_counter;

  output_port_scheduler #(.CNT_W(CNT_W), .GAP_CYCLES(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .p1_valid       (p1_valid),
    .p2_valid       (p2_valid),
    .p3_valid       (p3_valid),
    .p4_valid       (p4_valid),
    .p1_len         (p1_len),
    .p2_len         (p2_len),
    .p3_len         (p3_len),
    .p4_len         (p4_len),
    .out_ready      (out_ready),
    .grant          (grant),
    .word_rd        (word_rd),
    .out_valid      (out_valid),
    .pkt_start      (pkt_start),
    .pkt_end        (pkt_end),
    .active_packet  (active_packet),
    .priority_queue (priority_queue),
    .down_counter   (down_counter)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]       port;
    logic [CNT_W-1:0] cnt;
    logic             first;
    logic             last;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic logic [3:0] onehot(input int p);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[p-1] = 1'b1;
    return oh;
  endfunction

  task automatic push_words(input int port, input int len, input int n_words);
    for (int i = 0; i < n_words; i++) begin
      exp_t e;
      e.port  = 3'(port);
      e.cnt   = CNT_W'(len - i);
      e.first = (i == 0);
      e.last  = (i == len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic push_pkt(input int port, input int len);
    int eff;
    eff = (len == 0) ? 1 : len;
    push_words(port, eff, eff);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic [CNT_W-1:0] len);
    case (port)
      1: begin p1_valid = v; p1_len = len; end
      2: begin p2_valid = v; p2_len = len; end
      3: begin p3_valid = v; p3_len = len; end
      default: begin p4_valid = v; p4_len = len; end
    endcase
  endtask

  task automatic wait_pkt_start(output int c);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = pkt_start;
    end
    c = cyc;
    check("pkt_start_seen", 32'(pkt_start), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},   32'(grant),          32'd0);
    check({tag, "_word_rd"}, 32'(word_rd),        32'd0);
    check({tag, "_valid"},   32'(out_valid),      32'd0);
    check({tag, "_start"},   32'(pkt_start),      32'd0);
    check({tag, "_end"},     32'(pkt_end),        32'd0);
    check({tag, "_active"},  32'(active_packet),  32'd0);
    check({tag, "_prio"},    32'(priority_queue), 32'd0);
    check({tag, "_cnt"},     32'(down_counter),   32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && word_rd != 4'b0000) begin
      if (sb.size() == 0) begin
        check("extra_word", 32'(word_rd), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wd_word_rd", 32'(word_rd),        32'(onehot(int'(e.port))));
        check("wd_active",  32'(active_packet),  32'(e.port));
        check("wd_prio",    32'(priority_queue), 32'(e.port));
        check("wd_cnt",     32'(down_counter),   32'(e.cnt));
        check("wd_start",   32'(pkt_start),      32'(e.first));
        check("wd_end",     32'(pkt_end),        32'(e.last));
        check("wd_valid",   32'(out_valid),      32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c, cprev;
    p1_valid = 0; p2_valid = 0; p3_valid = 0; p4_valid = 0;
    p1_len = '0; p2_len = '0; p3_len = '0; p4_len = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_all_zero("rst");
    tick();
    reset = 1'b0;

    // All four requesting, length 2: strict 1,2,3,4,1 rotation, 4-cycle spacing.
    for (int p = 1; p <= 4; p++) set_req(p, 1'b1, CNT_W'(2));
    c0 = cyc;
    for (int n = 0; n < 5; n++) push_pkt((n % 4) + 1, 2);
    cprev = c0;
    for (int n = 0; n < 5; n++) begin
      wait_pkt_start(c);
      check("rr_grant",   32'(grant),          32'(onehot((n % 4) + 1)));
      check("rr_prio",    32'(priority_queue), 32'((n % 4) + 1));
      check("rr_spacing", 32'(c - cprev),      (n == 0) ? 32'd1 : 32'd4);
      cprev = c;
    end
    tick();
    for (int p = 1; p <= 4; p++) set_req(p, 1'b0, '0);
    drain();
    check("rr_prio_end", 32'(priority_queue), 32'd1);

    // Single requester p3, length 4: one-cycle grant latency.
    set_req(3, 1'b1, CNT_W'(4));
    push_pkt(3, 4);
    @(negedge clk);
    check("p3_grant_early", 32'(grant), 32'd0);
    tick();
    set_req(3, 1'b0, '0);
    @(negedge clk);
    check("p3_grant", 32'(grant),        32'b0100);
    check("p3_cnt",   32'(down_counter), 32'd4);
    drain();
    check("p3_prio",      32'(priority_queue), 32'd3);
    check("p3_cnt_done",  32'(down_counter),   32'd0);
    check("p3_grant_end", 32'(grant),          32'd0);
    check("p3_active",    32'(active_packet),  32'd0);

    // Wrap-around: with last served = 4, port 1 beats port 4, then 4 follows.
    set_req(4, 1'b1, CNT_W'(1));
    push_pkt(4, 1);
    wait_pkt_start(c);
    tick();
    set_req(4, 1'b0, '0);
    drain();
    check("wrap_prio4", 32'(priority_queue), 32'd4);
    set_req(1, 1'b1, CNT_W'(1));
    set_req(4, 1'b1, CNT_W'(1));
    push_pkt(1, 1);
    push_pkt(4, 1);
    wait_pkt_start(c);
    check("wrap_first", 32'(grant), 32'b0001);
    tick();
    set_req(1, 1'b0, '0);
    wait_pkt_start(c);
    check("wrap_second", 32'(grant), 32'b1000);
    tick();
    set_req(4, 1'b0, '0);
    drain();

    // Backpressure: p2 length 3 stalled for 5 cycles after its first word.
    set_req(2, 1'b1, CNT_W'(3));
    push_pkt(2, 3);
    wait_pkt_start(c);
    tick();
    set_req(2, 1'b0, '0);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_cnt",   32'(down_counter), 32'd2);
      check("stall_rd",    32'(word_rd),      32'd0);
      check("stall_valid", 32'(out_valid),    32'd1);
      check("stall_start", 32'(pkt_start),    32'd0);
      tick();
    end
    out_ready = 1'b1;
    drain();

    // Zero length is a one-word packet: start and end together.
    set_req(1, 1'b1, '0);
    push_pkt(1, 0);
    wait_pkt_start(c);
    check("len0_cnt", 32'(down_counter), 32'd1);
    check("len0_end", 32'(pkt_end),      32'd1);
    tick();
    set_req(1, 1'b0, '0);
    drain();

    // Asynchronous reset in the middle of a p3 packet with 5 words left.
    set_req(3, 1'b1, CNT_W'(8));
    push_words(3, 8, 3);
    wait_pkt_start(c);
    tick();
    set_req(3, 1'b0, '0);
    tick();
    tick();
    check("pre_reset_cnt", 32'(down_counter), 32'd5);
    check("pre_reset_sb",  32'(sb.size()),    32'd0);
    #1 reset = 1'b1;
    #1 check_all_zero("async_rst");
    sb.delete();
    set_req(2, 1'b1, CNT_W'(1));
    set_req(4, 1'b1, CNT_W'(1));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    c0 = cyc;
    push_pkt(2, 1);
    push_pkt(4, 1);
    wait_pkt_start(c);
    check("post_rst_grant",   32'(grant),  32'b0010);
    check("post_rst_latency", 32'(c - c0), 32'd1);
    tick();
    set_req(2, 1'b0, '0);
    wait_pkt_start(c);
    check("post_rst_second", 32'(grant), 32'b1000);
    tick();
    set_req(4, 1'b0, '0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
